count_window_ctrl: RTL and testbench
====================================

// Module: count_window_ctrl
// PURPOSE
//  Sequencer for the 8-bit ripple-enable event counter (flopr_c + xor/and chain).
//  Clears the counter, gates its enable E with an event input for a programmed
//  window of clock cycles, then captures the final count and overflow flag and
//  offers them on a valid/ready result port. One measurement at a time.
// PARAMETERS
//  CNT_W  8   counter width; must match the counter datapath
//  WIN_W  16  width of the window-length input and internal window down-counter
//  SAT    0   0: counter wraps at terminal count; 1: enable is gated off at terminal count (saturate)
// PORTS
//  ph1        in   1      single clock; all state updates on rising edge
//  reset      in   1      asynchronous, active-high; forces IDLE
//  start      in   1      request a measurement; sampled only in IDLE
//  win_len    in   WIN_W  window length in cycles; sampled with start
//  sample     in   1      event qualifier; counter increments on each RUN cycle with sample=1
//  cnt_val    in   CNT_W  counter output d[]
//  cnt_tc     in   1      counter terminal-count (all ones) flag q
//  cnt_en     out  1      drives counter E
//  cnt_rstb   out  1      drives counter resetb (active-low synchronous clear)
//  busy       out  1      high in CLEAR, RUN, SETTLE, HOLD
//  res_valid  out  1      result available (HOLD)
//  res_ready  in   1      consumer accepts result
//  res_count  out  CNT_W  captured count
//  res_ovf    out  1      counter wrapped (SAT=0) or hit terminal count with events pending (SAT=1)
// BEHAVIOUR
//  States: IDLE -> CLEAR -> RUN -> SETTLE -> HOLD -> IDLE.
//  Reset (async): state=IDLE, win counter=0, res_count=0, res_ovf=0, res_valid=0, busy=0,
//    cnt_en=0, cnt_rstb=0. Reset mid-measurement abandons it; no result is produced.
//  IDLE: cnt_rstb=0 (counter held clear). start=1 -> latch win_len, clear ovf, go CLEAR.
//  CLEAR: exactly 1 cycle, cnt_rstb=0. Next: RUN if latched win_len!=0, else SETTLE.
//  RUN: cnt_rstb=1; exactly win_len cycles; win counter decrements each cycle; last
//    cycle is when win counter==1 -> SETTLE.
//    cnt_en = sample & (state==RUN) & ~(SAT & cnt_tc). Combinational decode of registered state.
//    ovf set (sticky) on any RUN cycle with sample=1 and cnt_tc=1.
//  SETTLE: 1 cycle, cnt_en=0, lets final increment land in counter flops; next edge
//    captures res_count<=cnt_val, res_ovf<=ovf, enters HOLD.
//  HOLD: res_valid=1; res_count/res_ovf stable. res_valid&res_ready -> IDLE next edge.
//  Latency: start edge T -> RUN first cycle T+2 -> res_valid at T+win_len+3 (T+3 if win_len=0).
//  start outside IDLE is ignored (no queuing); start coincident with handshake in HOLD ignored.
//  Count arithmetic: SAT=0 -> res_count = events mod 2^CNT_W; SAT=1 -> min(events, 2^CNT_W-1).
//  win_len changes after the start cycle have no effect on the running window.
//  cnt_rstb=1 in RUN, SETTLE, HOLD; counter holds its value in SETTLE/HOLD since cnt_en=0.
// TESTING
//  (bench instantiates this block with a behavioural 8-bit counter model, SAT=0 unless noted)
//  T1 win_len=10, sample=1 throughout, res_ready=1 -> res_valid at T+13, res_count=10, res_ovf=0.
//  T2 win_len=8, sample toggling 1,0,1,0... starting high -> res_count=4, res_ovf=0.
//  T3 win_len=300, sample=1 -> SAT=0: res_count=44, res_ovf=1; SAT=1: res_count=255, res_ovf=1.
//  T4 win_len=0, start -> CLEAR then SETTLE, res_valid at T+3, res_count=0, res_ovf=0.
//  T5 result backpressure: res_ready=0 for 5 cycles, pulse start during HOLD -> res_count/res_ovf
//     stable, busy=1, no new measurement; res_ready=1 -> IDLE next edge, busy=0.
//  T6 reset asserted in RUN (cycle 4 of 10) -> immediately IDLE, cnt_en=0, cnt_rstb=0,
//     res_valid=0; after release, new start with win_len=3, sample=1 -> res_count=3.

Source files
------------

// File: rtl/count_window_ctrl.sv
// Measurement sequencer for an external ripple-enable event counter.
// It clears the counter, opens an event window for a programmed number of cycles, then captures the count.
module count_window_ctrl #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16,
    parameter bit SAT   = 1'b0
) (
    input  logic             ph1_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIN_W-1:0] win_len_i,
    input  logic             sample_i,
    input  logic [CNT_W-1:0] cnt_val_i,
    input  logic             cnt_tc_i,
    output logic             cnt_en_o,
    output logic             cnt_rstb_o,
    output logic             busy_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [CNT_W-1:0] res_count_o,
    output logic             res_ovf_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic             res_ovf_q, res_ovf_d;

    always_ff @(posedge ph1_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            win_q       <= '0;
            ovf_q       <= 1'b0;
            res_count_q <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            ovf_q       <= ovf_d;
            res_count_q <= res_count_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        ovf_d       = ovf_q;
        res_count_d = res_count_q;
        res_ovf_d   = res_ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    win_d   = win_len_i;
                    ovf_d   = 1'b0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = (win_q != '0) ? S_RUN : S_SETTLE;
            end
            S_RUN: begin
                win_d = win_q - WIN_W'(1);
                // An event arriving while the counter sits at all-ones either wraps it or is dropped.
                if (sample_i && cnt_tc_i) begin
                    ovf_d = 1'b1;
                end
                if (win_q == WIN_W'(1)) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                res_count_d = cnt_val_i;
                res_ovf_d   = ovf_q;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Enable is a pure decode of registered state so the counter sees exactly win_len gated cycles.
    assign cnt_en_o    = (state_q == S_RUN) & sample_i & ~(SAT & cnt_tc_i);
    assign cnt_rstb_o  = (state_q == S_RUN) | (state_q == S_SETTLE) | (state_q == S_HOLD);
    assign busy_o      = (state_q != S_IDLE);
    assign res_valid_o = (state_q == S_HOLD);
    assign res_count_o = res_count_q;
    assign res_ovf_o   = res_ovf_q;

endmodule

// File: tb/tb_count_window_ctrl.sv
// Directed bench for count_window_ctrl: a wrapping and a saturating instance run side by side,
// each driving its own behavioural 8-bit counter.
module tb_count_window_ctrl;

    localparam int CNT_W = 8;
    localparam int WIN_W = 16;
    localparam int LIMIT = 400;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIN_W-1:0] win_len = '0;
    logic             sample = 1'b0;
    logic             res_ready = 1'b1;

    logic [CNT_W-1:0] cnt_a = '0, cnt_b = '0;
    logic             tc_a, tc_b;
    logic             en_a, en_b, rstb_a, rstb_b;
    logic             busy_a, busy_b, valid_a, valid_b;
    logic [CNT_W-1:0] rcnt_a, rcnt_b;
    logic             rovf_a, rovf_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign tc_a = (cnt_a == 8'hFF);
    assign tc_b = (cnt_b == 8'hFF);

    always @(posedge clk) begin
        if (!rstb_a)   cnt_a <= '0;
        else if (en_a) cnt_a <= cnt_a + 8'd1;
        if (!rstb_b)   cnt_b <= '0;
        else if (en_b) cnt_b <= cnt_b + 8'd1;
    end

    count_window_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SAT(1'b0)) u_dut (
        .ph1_i(clk), .reset_i(rst), .start_i(start), .win_len_i(win_len),
        .sample_i(sample), .cnt_val_i(cnt_a), .cnt_tc_i(tc_a),
        .cnt_en_o(en_a), .cnt_rstb_o(rstb_a), .busy_o(busy_a),
        .res_valid_o(valid_a), .res_ready_i(res_ready),
        .res_count_o(rcnt_a), .res_ovf_o(rovf_a)
    );

    count_window_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SAT(1'b1)) u_dut_sat (
        .ph1_i(clk), .reset_i(rst), .start_i(start), .win_len_i(win_len),
        .sample_i(sample), .cnt_val_i(cnt_b), .cnt_tc_i(tc_b),
        .cnt_en_o(en_b), .cnt_rstb_o(rstb_b), .busy_o(busy_b),
        .res_valid_o(valid_b), .res_ready_i(res_ready),
        .res_count_o(rcnt_b), .res_ovf_o(rovf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Start a measurement and wait for res_valid; mode 0 holds sample high,
    // mode 1 toggles it 1,0,1,... beginning on the first RUN cycle.
    task automatic run_meas(input string tag, input int win, input int mode, input int exp_lat,
                            input int exp_cnt_a, input int exp_ovf_a,
                            input int exp_cnt_b, input int exp_ovf_b);
        int k;
        bit seen;
        start   = 1'b1;
        win_len = WIN_W'(win);
        sample  = (mode == 0);
        @(posedge clk); #1;
        start   = 1'b0;
        win_len = 16'hBEEF;
        k = 1;
        seen = 1'b0;
        check({tag, " clear busy"}, 32'(busy_a), 32'd1);
        check({tag, " clear rstb"}, 32'(rstb_a), 32'd0);
        while (k < LIMIT) begin
            if (valid_a) begin
                seen = 1'b1;
                break;
            end
            if (mode == 1) sample = (k >= 2) && (((k - 2) % 2) == 0);
            @(posedge clk); #1;
            k++;
            if (k == 2 && win > 0) check({tag, " run rstb"}, 32'(rstb_a), 32'd1);
        end
        check({tag, " seen valid"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(k), 32'(exp_lat));
        check({tag, " count"}, 32'(rcnt_a), 32'(exp_cnt_a));
        check({tag, " ovf"}, 32'(rovf_a), 32'(exp_ovf_a));
        check({tag, " sat valid"}, 32'(valid_b), 32'd1);
        check({tag, " sat count"}, 32'(rcnt_b), 32'(exp_cnt_b));
        check({tag, " sat ovf"}, 32'(rovf_b), 32'(exp_ovf_b));
        sample = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(busy_a), 32'd0);
        check("rst valid", 32'(valid_a), 32'd0);
        check("rst en", 32'(en_a), 32'd0);
        check("rst rstb", 32'(rstb_a), 32'd0);
        check("rst count", 32'(rcnt_a), 32'd0);
        check("rst ovf", 32'(rovf_a), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1
        res_ready = 1'b1;
        run_meas("T1", 10, 0, 13, 10, 0, 10, 0);
        @(posedge clk); #1;
        check("T1 idle busy", 32'(busy_a), 32'd0);
        check("T1 idle valid", 32'(valid_a), 32'd0);

        // T2
        run_meas("T2", 8, 1, 11, 4, 0, 4, 0);
        @(posedge clk); #1;

        // T3: 300 events wrap to 44 or saturate at 255
        run_meas("T3", 300, 0, 303, 44, 1, 255, 1);
        @(posedge clk); #1;

        // T4: zero-length window
        run_meas("T4", 0, 0, 3, 0, 0, 0, 0);
        @(posedge clk); #1;

        // T5: backpressure, ignored start in HOLD and at the handshake edge
        res_ready = 1'b0;
        run_meas("T5", 2, 0, 5, 2, 0, 2, 0);
        for (int i = 0; i < 5; i++) begin
            start   = (i == 2);
            win_len = 16'd5;
            @(posedge clk); #1;
            check("T5 hold valid", 32'(valid_a), 32'd1);
            check("T5 hold busy", 32'(busy_a), 32'd1);
            check("T5 hold count", 32'(rcnt_a), 32'd2);
        end
        start     = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("T5 release busy", 32'(busy_a), 32'd0);
        check("T5 release valid", 32'(valid_a), 32'd0);
        @(posedge clk); #1;
        check("T5 no requeue", 32'(busy_a), 32'd0);

        // T6: reset during RUN cycle 4 of 10
        start   = 1'b1;
        win_len = 16'd10;
        sample  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("T6 run en", 32'(en_a), 32'd1);
        rst = 1'b1;
        #1;
        check("T6 rst busy", 32'(busy_a), 32'd0);
        check("T6 rst en", 32'(en_a), 32'd0);
        check("T6 rst rstb", 32'(rstb_a), 32'd0);
        check("T6 rst valid", 32'(valid_a), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sample = 1'b0;
        @(posedge clk); #1;
        run_meas("T6", 3, 0, 6, 3, 0, 3, 0);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
